neuron_mac_q6_10: RTL and testbench

- Upstream stage of the Q6.10 sigmoid activation unit: computes one neuron's pre-activation z = bias + sum(x_i * w_i) over N_INPUTS serially delivered operand pairs.
- Rounds and saturates z back to 16-bit Q6.10 (6 integer bits incl. sign, 10 fraction bits) and presents it on a valid/ready output that drives the sigmoid input directly.
- Sequential: one multiply-accumulate per accepted beat, with a small FSM and a handshake on both sides.

---
 rtl/neuron_mac_q6_10.sv | 142 ++++++++++++++
 tb/tb_neuron_mac_q6_10.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_mac_q6_10.sv
`default_nettype none
// ============================================================================
// Module   : neuron_mac_q6_10
// Purpose  : Serial multiply-accumulate of one neuron's Q6.10 pre-activation
//            with rounding and saturation to Q6.10 on a valid/ready output.
// Revision : 1.0  initial release
// ============================================================================
module neuron_mac_q6_10 #(
    parameter int N_INPUTS = 4,
    parameter int DATA_W   = 16,
    parameter int FRAC_W   = 10,
    parameter int ACC_W    = 40
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] bias,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] x_in,
    input  logic [DATA_W-1:0] w_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] sum_out,
    output logic              overflow,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCUM  = 2'd1,
        S_ROUND  = 2'd2,
        S_OUTPUT = 2'd3
    } state_t;

    localparam logic [7:0]              c_last    = 8'(N_INPUTS - 1);
    localparam logic signed [ACC_W-1:0] c_half    = ACC_W'(2 ** (FRAC_W - 1));
    localparam logic signed [ACC_W-1:0] c_sat_max = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] c_sat_min = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic signed [ACC_W-1:0]   r_acc;
    logic [7:0]                r_count;
    logic [DATA_W-1:0]         r_sum;
    logic                      r_ovf;

    logic                      w_fire;
    logic                      w_last;
    logic signed [2*DATA_W-1:0] w_x_ext;
    logic signed [2*DATA_W-1:0] w_w_ext;
    logic signed [2*DATA_W-1:0] w_prod;
    logic signed [ACC_W-1:0]   w_prod_ext;
    logic signed [ACC_W-1:0]   w_bias_ext;
    logic signed [ACC_W-1:0]   w_rnd;
    logic signed [ACC_W-1:0]   w_r;
    logic [DATA_W-1:0]         w_sat;
    logic                      w_sat_ovf;

    assign w_fire = in_valid && (r_state == S_ACCUM);
    assign w_last = w_fire && (r_count == c_last);

    // Operands widened first so the product is a full-width signed Q12.20.
    assign w_x_ext    = {{DATA_W{x_in[DATA_W-1]}}, x_in};
    assign w_w_ext    = {{DATA_W{w_in[DATA_W-1]}}, w_in};
    assign w_prod     = w_x_ext * w_w_ext;
    assign w_prod_ext = {{(ACC_W-2*DATA_W){w_prod[2*DATA_W-1]}}, w_prod};
    assign w_bias_ext = {{(ACC_W-DATA_W-FRAC_W){bias[DATA_W-1]}}, bias, {FRAC_W{1'b0}}};

    // Add half an LSB then arithmetic shift: round half toward +inf.
    assign w_rnd = r_acc + c_half;
    assign w_r   = w_rnd >>> FRAC_W;

    always_comb begin
        w_sat     = w_r[DATA_W-1:0];
        w_sat_ovf = 1'b0;
        if (w_r > c_sat_max) begin
            w_sat     = {1'b0, {(DATA_W-1){1'b1}}};
            w_sat_ovf = 1'b1;
        end else if (w_r < c_sat_min) begin
            w_sat     = {1'b1, {(DATA_W-1){1'b0}}};
            w_sat_ovf = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (start)     w_state_nxt = S_ACCUM;
            S_ACCUM:  if (w_last)    w_state_nxt = S_ROUND;
            S_ROUND:                 w_state_nxt = S_OUTPUT;
            S_OUTPUT: if (out_ready) w_state_nxt = S_IDLE;
            default:                 w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc   <= '0;
            r_count <= '0;
            r_sum   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_acc   <= w_bias_ext;
                        r_count <= '0;
                        r_ovf   <= 1'b0;
                    end
                end
                S_ACCUM: begin
                    if (w_fire) begin
                        r_acc   <= r_acc + w_prod_ext;
                        r_count <= r_count + 8'd1;
                    end
                end
                S_ROUND: begin
                    r_sum <= w_sat;
                    r_ovf <= w_sat_ovf;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == S_ACCUM);
    assign out_valid = (r_state == S_OUTPUT);
    assign busy      = (r_state != S_IDLE);
    assign sum_out   = r_sum;
    assign overflow  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_neuron_mac_q6_10.sv
`default_nettype none
// ============================================================================
// Module   : tb_neuron_mac_q6_10
// Purpose  : Scoreboard bench for neuron_mac_q6_10 (N_INPUTS = 4).
// Revision : 1.0  initial release
// ============================================================================
module tb_neuron_mac_q6_10;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] bias;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] x_in;
    logic [15:0] w_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum_out;
    logic        overflow;
    logic        busy;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [16:0] sb_q[$];
    logic [16:0] sb_e;

    always #5 clk = ~clk;

    neuron_mac_q6_10 #(
        .N_INPUTS(4),
        .DATA_W  (16),
        .FRAC_W  (10),
        .ACC_W   (40)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .bias     (bias),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .x_in     (x_in),
        .w_in     (w_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum_out  (sum_out),
        .overflow (overflow),
        .busy     (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Reference: exact integer sum, round half up, clamp to Q6.10.
    function automatic logic [16:0] model(input logic [15:0] b, input logic [15:0] xs[4],
                                          input logic [15:0] ws[4]);
        longint acc;
        longint r;
        logic [15:0] lo;
        acc = longint'($signed(b)) * 1024;
        for (int i = 0; i < 4; i++)
            acc += longint'($signed(xs[i])) * longint'($signed(ws[i]));
        r = (acc + 512) >>> 10;
        if (r > 32767)  return {1'b1, 16'h7FFF};
        if (r < -32768) return {1'b1, 16'h8000};
        lo = r[15:0];
        return {1'b0, lo};
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    check("sb_unexpected", 32'd1, 32'd0);
                end else begin
                    sb_e = sb_q.pop_front();
                    check("sb_sum", {16'h0, sum_out}, {16'h0, sb_e[15:0]});
                    check("sb_ovf", {31'h0, overflow}, {31'h0, sb_e[16]});
                end
            end
        end
    end

    task automatic run_eval(input string name, input logic [15:0] b, input logic [15:0] xs[4],
                            input logic [15:0] ws[4], input logic [15:0] vpat,
                            input int stall, input bit poke_start);
        logic [16:0] exp;
        int          idx;
        int          cyc;
        bit          fire;
        exp = model(b, xs, ws);
        @(posedge clk); #1;
        check({name, "_idle_rdy"}, {31'h0, in_ready}, 32'd0);
        start = 1'b1;
        bias  = b;
        sb_q.push_back(exp);
        @(posedge clk); #1;
        start = 1'b0;
        bias  = 16'h0;
        check({name, "_busy"}, {31'h0, busy}, 32'd1);
        idx = 0;
        cyc = 0;
        while (idx < 4 && cyc < 40) begin
            in_valid = (cyc < 16) ? vpat[cyc] : 1'b1;
            x_in     = xs[idx];
            w_in     = ws[idx];
            @(negedge clk);
            fire = in_valid && in_ready;
            if (poke_start) check({name, "_busy_acc"}, {31'h0, busy}, 32'd1);
            @(posedge clk); #1;
            if (fire) idx++;
            cyc++;
        end
        check({name, "_beats"}, idx, 32'd4);
        // Junk operands offered while not ready must not be consumed.
        in_valid = 1'b1;
        x_in     = 16'h7FFF;
        w_in     = 16'h7FFF;
        check({name, "_round_ov"}, {31'h0, out_valid}, 32'd0);
        check({name, "_round_rdy"}, {31'h0, in_ready}, 32'd0);
        @(posedge clk); #1;
        check({name, "_lat_ov"}, {31'h0, out_valid}, 32'd1);
        check({name, "_sum"}, {16'h0, sum_out}, {16'h0, exp[15:0]});
        check({name, "_ovf"}, {31'h0, overflow}, {31'h0, exp[16]});
        for (int s = 0; s < stall; s++) begin
            start = poke_start;
            @(posedge clk); #1;
            check({name, "_stall_ov"}, {31'h0, out_valid}, 32'd1);
            check({name, "_stall_sum"}, {16'h0, sum_out}, {16'h0, exp[15:0]});
            check({name, "_stall_busy"}, {31'h0, busy}, 32'd1);
            check({name, "_stall_rdy"}, {31'h0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        start     = poke_start;
        @(posedge clk); #1;
        out_ready = 1'b0;
        start     = 1'b0;
        in_valid  = 1'b0;
        check({name, "_done_ov"}, {31'h0, out_valid}, 32'd0);
        check({name, "_done_busy"}, {31'h0, busy}, 32'd0);
        check({name, "_retain"}, {16'h0, sum_out}, {16'h0, exp[15:0]});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] xa[4];
        logic [15:0] wa[4];
        rst_n     = 1'b0;
        start     = 1'b0;
        bias      = 16'h0;
        in_valid  = 1'b0;
        x_in      = 16'h0;
        w_in      = 16'h0;
        out_ready = 1'b0;
        #12;
        check("rst_sum", {16'h0, sum_out}, 32'd0);
        check("rst_ovf", {31'h0, overflow}, 32'd0);
        check("rst_ov", {31'h0, out_valid}, 32'd0);
        check("rst_rdy", {31'h0, in_ready}, 32'd0);
        check("rst_busy", {31'h0, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        xa = '{16'h0400, 16'h0400, 16'h0400, 16'h0400};
        wa = '{16'h0400, 16'h0400, 16'h0400, 16'h0400};
        run_eval("ones", 16'h0000, xa, wa, 16'hFFFF, 0, 1'b0);

        wa = '{16'h0001, 16'h0001, 16'h0001, 16'h0001};
        run_eval("negbias", 16'hF000, xa, wa, 16'hFFFF, 0, 1'b0);

        xa = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
        wa = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
        run_eval("satpos", 16'h0000, xa, wa, 16'hFFFF, 1, 1'b0);

        xa = '{16'h8000, 16'h8000, 16'h8000, 16'h8000};
        run_eval("satneg", 16'h0000, xa, wa, 16'hFFFF, 0, 1'b0);

        xa = '{16'h0001, 16'h0000, 16'h0000, 16'h0000};
        wa = '{16'h0200, 16'h0000, 16'h0000, 16'h0000};
        run_eval("rnd_up", 16'h0000, xa, wa, 16'hFFFF, 0, 1'b0);

        xa = '{16'hFFFF, 16'h0000, 16'h0000, 16'h0000};
        run_eval("rnd_zero", 16'h0000, xa, wa, 16'hFFFF, 0, 1'b0);

        xa = '{16'h0400, 16'h0400, 16'h0400, 16'h0400};
        wa = '{16'h0400, 16'h0400, 16'h0400, 16'h0400};
        run_eval("bp", 16'h0200, xa, wa, 16'h0059, 3, 1'b1);

        // Abort after two beats: outputs clear at once, no result emitted.
        xa = '{16'h8000, 16'h8000, 16'h8000, 16'h8000};
        wa = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
        run_eval("presat", 16'h0000, xa, wa, 16'hFFFF, 0, 1'b0);
        @(posedge clk); #1;
        start = 1'b1;
        bias  = 16'h0C00;
        @(posedge clk); #1;
        start    = 1'b0;
        in_valid = 1'b1;
        x_in     = 16'h0400;
        w_in     = 16'h0400;
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("abort_sum", {16'h0, sum_out}, 32'd0);
        check("abort_ovf", {31'h0, overflow}, 32'd0);
        check("abort_rdy", {31'h0, in_ready}, 32'd0);
        check("abort_ov", {31'h0, out_valid}, 32'd0);
        check("abort_busy", {31'h0, busy}, 32'd0);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        wa = '{16'h0400, 16'h0400, 16'h0400, 16'h0400};
        xa = '{16'h0400, 16'h0400, 16'h0400, 16'h0400};
        run_eval("fresh", 16'h0000, xa, wa, 16'hFFFF, 0, 1'b0);

        repeat (2) @(posedge clk);
        #1;
        check("sb_empty", sb_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
